// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the register-window datapath.
// The controller side (master) reads the fetched instruction and status flags and
// drives every datapath strobe and select; the datapath side (slave) is the mirror.
interface multicycle_controller_if;
  logic [15:0] instructionIn;
  logic        Zero;
  logic        MemoryReady;
  logic        RegisterWriteDataEnable;
  logic        LoadPcEnable;
  logic        SelectBranchPc;
  logic        SelectJumpPc;
  logic        MemoryWriteDataEnable;
  logic        MemoryReadDataEnable;
  logic        SelectImm;
  logic [1:0]  Window;
  logic        Halted;
  logic        Illegal;
  logic [15:0] RetiredCount;

  modport master (
    input  instructionIn, Zero, MemoryReady,
    output RegisterWriteDataEnable, LoadPcEnable, SelectBranchPc, SelectJumpPc,
           MemoryWriteDataEnable, MemoryReadDataEnable, SelectImm,
           Window, Halted, Illegal, RetiredCount
  );

  modport slave (
    output instructionIn, Zero, MemoryReady,
    input  RegisterWriteDataEnable, LoadPcEnable, SelectBranchPc, SelectJumpPc,
           MemoryWriteDataEnable, MemoryReadDataEnable, SelectImm,
           Window, Halted, Illegal, RetiredCount
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit register-window CPU.
// Latches the fetched instruction, sequences FETCH/DECODE/EXEC/MEM/WB, decodes the
// datapath strobes from state and instruction, owns the register-window pointer,
// a sticky illegal-opcode flag and a wrapping retired-instruction counter.
// Only the instruction bits the controller decodes (opcode and window select) are
// held here; the datapath keeps its own copy of the full instruction word.
module multicycle_controller (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALUR  = 4'h1;
  localparam logic [3:0] OP_ALUI  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_JUMP  = 4'h5;
  localparam logic [3:0] OP_BZ    = 4'h6;
  localparam logic [3:0] OP_WIN   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q;
  logic [1:0]  winSel_q;
  logic [1:0]  window_q;
  logic        illegal_q;
  logic [15:0] retired_q;

  logic opLegal;
  logic regWrite, loadPc, selBranch, selJump, memWrite, memRead, selImm;

  assign opLegal = opcode_q inside {OP_NOP, OP_ALUR, OP_ALUI, OP_LOAD, OP_STORE,
                                    OP_JUMP, OP_BZ, OP_WIN, OP_HALT};

  // Next-state and Moore strobe decode from the current state and latched opcode
  always_comb begin
    state_d   = state_q;
    regWrite  = 1'b0;
    loadPc    = 1'b0;
    selBranch = 1'b0;
    selJump   = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    selImm    = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (!opLegal || opcode_q == OP_NOP) begin
          loadPc  = 1'b1;
          state_d = FETCH;
        end else begin
          case (opcode_q)
            OP_JUMP: begin
              loadPc  = 1'b1;
              selJump = 1'b1;
              state_d = FETCH;
            end
            OP_WIN: begin
              loadPc  = 1'b1;
              state_d = FETCH;
            end
            OP_HALT: state_d = HALT;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        selImm = opcode_q inside {OP_ALUI, OP_LOAD, OP_STORE};
        case (opcode_q)
          OP_BZ: begin
            loadPc    = 1'b1;
            selBranch = bus.Zero;
            state_d   = FETCH;
          end
          OP_ALUR, OP_ALUI:  state_d = WB;
          OP_LOAD, OP_STORE: state_d = MEM;
          default:           state_d = FETCH;
        endcase
      end
      MEM: begin
        case (opcode_q)
          OP_LOAD: begin
            memRead = 1'b1;
            if (bus.MemoryReady) state_d = WB;
          end
          OP_STORE: begin
            memWrite = 1'b1;
            if (bus.MemoryReady) begin
              loadPc  = 1'b1;
              state_d = FETCH;
            end
          end
          default: state_d = FETCH;
        endcase
      end
      WB: begin
        regWrite = 1'b1;
        loadPc   = 1'b1;
        selImm   = (opcode_q == OP_ALUI);
        state_d  = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // FSM state, instruction latch, window pointer, illegal flag and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      opcode_q  <= 4'h0;
      winSel_q  <= 2'b00;
      window_q  <= 2'b00;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        opcode_q <= bus.instructionIn[15:12];
        winSel_q <= bus.instructionIn[1:0];
      end
      if (state_q == DECODE && opcode_q == OP_WIN) window_q <= winSel_q;
      if (state_q == DECODE && !opLegal) illegal_q <= 1'b1;
      if (loadPc) retired_q <= retired_q + 16'd1;
    end
  end

  assign bus.RegisterWriteDataEnable = regWrite;
  assign bus.LoadPcEnable            = loadPc;
  assign bus.SelectBranchPc          = selBranch;
  assign bus.SelectJumpPc            = selJump;
  assign bus.MemoryWriteDataEnable   = memWrite;
  assign bus.MemoryReadDataEnable    = memRead;
  assign bus.SelectImm               = selImm;
  assign bus.Window                  = window_q;
  assign bus.Halted                  = (state_q == HALT);
  assign bus.Illegal                 = illegal_q;
  assign bus.RetiredCount            = retired_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the 16-bit register-window CPU. It latches each fetched instruction from the datapath's instruction output and sequences the datapath enables and mux selects (PC load, branch/jump select, register write, memory read/write, immediate select). It also owns the current register-window pointer. It sits directly downstream of the datapath's instruction output and upstream of every datapath control input, and waits on a memory-ready handshake for loads and stores.

## Interface
Parameters:
- none

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- instructionIn  input  16  current instruction from the datapath, valid during FETCH
- Zero  input  1  ALU zero flag, sampled in EXEC of BZ
- MemoryReady  input  1  memory completes the current access this cycle; ignored outside MEM
- RegisterWriteDataEnable  output  1  register file write strobe
- LoadPcEnable  output  1  PC load strobe; PC+1 when both selects are 0
- SelectBranchPc  output  1  PC source = branch target
- SelectJumpPc  output  1  PC source = jump target
- MemoryWriteDataEnable  output  1  data memory write request
- MemoryReadDataEnable  output  1  data memory read request
- SelectImm  output  1  ALU B input = instruction[7:0]
- Window  output  2  register window pointer
- Halted  output  1  FSM is in HALT
- Illegal  output  1  sticky flag: an undefined opcode was decoded
- RetiredCount  output  16  count of retired instructions; wraps

## Operation
- IR (16 b) captures instructionIn on the FETCH→DECODE edge. All decode uses IR; opcode = IR[15:12].
- Opcodes: 0x0 NOP, 0x1 ALU reg-reg, 0x2 ALU immediate, 0x3 LOAD, 0x4 STORE, 0x5 JUMP, 0x6 BZ, 0x7 WIN, 0xF HALT. All other opcodes are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- Control outputs are a combinational (Moore) decode of state and IR. Each is 0 unless listed below.
- FETCH: no strobes. Always goes to DECODE.
- DECODE:
  - NOP and illegal: LoadPcEnable=1, → FETCH. Illegal also sets Illegal.
  - JUMP: LoadPcEnable=1, SelectJumpPc=1, → FETCH.
  - WIN: LoadPcEnable=1; Window←IR[1:0] at the same edge; → FETCH.
  - HALT: → HALT, with no PC load.
  - All other opcodes: → EXEC.
- EXEC:
  - SelectImm=1 for 0x2, 0x3 and 0x4.
  - BZ: LoadPcEnable=1, SelectBranchPc=Zero, → FETCH.
  - 0x1 and 0x2: → WB.
  - 0x3 and 0x4: → MEM.
- MEM: holds MemoryReadDataEnable (LOAD) or MemoryWriteDataEnable (STORE) high every cycle until MemoryReady=1.
  - LOAD: on the ready cycle → WB.
  - STORE: the ready cycle also asserts LoadPcEnable=1, then → FETCH.
  - The wait is unbounded; there is no timeout.
- WB: RegisterWriteDataEnable=1 and LoadPcEnable=1. SelectImm is held for 0x2. → FETCH.
- HALT: all strobes 0, Halted=1, stays in HALT until reset.
- RetiredCount increments by 1 in every cycle where LoadPcEnable=1, wrapping 0xFFFF→0x0000.
- A HALT instruction is not counted.

## Timing
- Reset (asynchronous, active-low) forces immediately, independent of clk: state=FETCH, IR=0, Window=0, Illegal=0, RetiredCount=0, every strobe 0, Halted=0.
- Reset asserted mid-instruction (including during a MEM wait) aborts the instruction. No partial PC or register update is issued after reset assertion.
- First FETCH after reset: the first rising edge following rst deassertion.
- Cycles per instruction, counted from FETCH up to and including the retiring cycle:
  - NOP, JUMP, WIN, illegal: 2
  - BZ: 3
  - ALU reg-reg and ALU immediate: 4
  - STORE: 4+w
  - LOAD: 5+w
  - w = number of MEM cycles with MemoryReady=0.
- MemoryReady high on the first MEM cycle gives w=0.
- Zero and MemoryReady are sampled only in their stated states; values at other times have no effect.
- Window changes one edge after the WIN DECODE cycle. Instructions that follow see the new window.

## Test plan
- Reset: drive rst=0 mid-LOAD MEM wait → all outputs 0 and Window=0 at once. Release, then NOP 0x0000 → LoadPcEnable pulses in cycle 2 and RetiredCount=1.
- ALU immediate 0x2105 → EXEC and WB assert SelectImm=1; WB asserts RegisterWriteDataEnable=1 and LoadPcEnable=1; total 4 cycles.
- LOAD 0x3000 with MemoryReady low for 3 MEM cycles → MemoryReadDataEnable high for 4 cycles, then WB; total 8 cycles. STORE 0x4000 with w=0 → MemoryWriteDataEnable and LoadPcEnable in the same cycle; total 4 cycles.
- BZ 0x6000:
  - Zero=1 → EXEC asserts LoadPcEnable=1 and SelectBranchPc=1.
  - Zero=0 → SelectBranchPc=0.
  - JUMP 0x5ABC → DECODE asserts SelectJumpPc=1; total 2 cycles.
- WIN 0x7003 → Window=3 after DECODE. Opcode 0x9000 → Illegal=1 and stays 1 after a following NOP; PC still advances.
- HALT 0xF000 → Halted=1, no strobes for 20 cycles, RetiredCount unchanged. Preload RetiredCount to 0xFFFF with NOPs, then one more NOP → 0x0000.
